// File: rtl/hamming_pkg.sv
// -----------------------------------------------------------------------------
// hamming_pkg
// Shared definitions for the Hamming(7,4) link (transmit and receive sides).
//   - Codeword position constants: parity at 1/2/4, data at 3/5/6/7.
//   - tx_state_e: serial transmitter frame states.
//   - hamming_encode(): 4-bit nibble -> 7-bit codeword indexed [7:1].
// -----------------------------------------------------------------------------
package hamming_pkg;

    localparam int DATA_W = 4;
    localparam int CODE_W = 7;

    // Parity positions (also the syndrome weights on the decoder side)
    localparam int P1 = 1;
    localparam int P2 = 2;
    localparam int P4 = 4;

    // Data bit positions d0..d3
    localparam int D0_POS = 3;
    localparam int D1_POS = 5;
    localparam int D2_POS = 6;
    localparam int D3_POS = 7;

    localparam logic [2:0] LAST_POS = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    function automatic logic [7:1] hamming_encode(input logic [3:0] d);
        logic [7:1] c;
        c         = '0;
        c[D0_POS] = d[0];
        c[D1_POS] = d[1];
        c[D2_POS] = d[2];
        c[D3_POS] = d[3];
        c[P1]     = d[0] ^ d[1] ^ d[3];
        c[P2]     = d[0] ^ d[2] ^ d[3];
        c[P4]     = d[1] ^ d[2] ^ d[3];
        return c;
    endfunction

endpackage

// File: rtl/hamming_enc.sv
// -----------------------------------------------------------------------------
// hamming_enc
// Pure combinational Hamming(7,4) encoder.
//   data_i [3:0]  data nibble d[3:0]
//   code_o [7:1]  codeword indexed by Hamming position (parity at 1/2/4)
// -----------------------------------------------------------------------------
module hamming_enc
    import hamming_pkg::*;
(
    input  logic [3:0] data_i,
    output logic [7:1] code_o
);

    assign code_o = hamming_encode(data_i);

endmodule

// File: rtl/hamming_enc_tx.sv
// -----------------------------------------------------------------------------
// hamming_enc_tx
// Serial Hamming(7,4) transmitter. Accepts a nibble on a valid/ready handshake,
// encodes it (with optional single-bit error injection) and shifts the frame
// out as: start(0), c[1]..c[7], stop(1), each bit CLKS_PER_BIT cycles long.
//
// Handshake: a nibble is taken on a rising edge where in_valid & in_ready;
// in_ready is high only in IDLE, there is no buffering, and in_valid outside
// IDLE is ignored, so upstream must hold its data until in_ready.
//
// Ports
//   clock       rising-edge clock
//   reset       asynchronous active-high reset (aborts any frame at once)
//   in_data     data nibble d[3:0]
//   in_err_pos  codeword position 1..7 to invert, 0 = clean
//   in_valid    in_data/in_err_pos valid
//   in_ready    block can accept (combinational, FSM in IDLE)
//   code_out    registered codeword [7:1] after injection
//   code_valid  one-cycle pulse when code_out updates
//   tx_serial   registered serial line, idles high
//   busy        registered, frame in progress
// -----------------------------------------------------------------------------
module hamming_enc_tx
    import hamming_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] in_data,
    input  logic [2:0] in_err_pos,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:1] code_out,
    output logic       code_valid,
    output logic       tx_serial,
    output logic       busy
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);

    tx_state_e     state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    idx_q,   idx_d;
    logic [7:1]    code_q,  code_d;
    logic          tx_q,    tx_d;
    logic          cv_q,    cv_d;
    logic          busy_q,  busy_d;

    logic [7:1] enc_code;
    logic [7:0] err_shift;
    logic [7:0] code_ext;
    logic [2:0] idx_nxt;
    logic       bit_done;

    hamming_enc u_enc (
        .data_i (in_data),
        .code_o (enc_code)
    );

    // One-hot mask over positions 0..7; position 0 ("no injection") falls off
    // the bottom when the mask is trimmed to [7:1].
    assign err_shift = 8'b1 << in_err_pos;

    // Pad position 0 so a 3-bit index selects a codeword bit directly.
    assign code_ext = {code_q, 1'b0};
    assign idx_nxt  = idx_q + 3'd1;
    assign bit_done = (timer_q == TMAX);

    assign in_ready = (state_q == ST_IDLE);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        code_d  = code_q;
        tx_d    = tx_q;
        cv_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_d    = 1'b1;
                timer_d = '0;
                idx_d   = '0;
                if (in_valid) begin
                    state_d = ST_START;
                    code_d  = enc_code ^ err_shift[7:1];
                    cv_d    = 1'b1;
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    timer_d = '0;
                    state_d = ST_DATA;
                    idx_d   = 3'd1;
                    tx_d    = code_q[P1];
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    timer_d = '0;
                    if (idx_q == LAST_POS) begin
                        state_d = ST_STOP;
                        idx_d   = '0;
                        tx_d    = 1'b1;
                    end else begin
                        idx_d = idx_nxt;
                        tx_d  = code_ext[idx_nxt];
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (bit_done) begin
                    timer_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
                idx_d   = '0;
                tx_d    = 1'b1;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            code_q  <= '0;
            tx_q    <= 1'b1;
            cv_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            code_q  <= code_d;
            tx_q    <= tx_d;
            cv_q    <= cv_d;
            busy_q  <= busy_d;
        end
    end

    assign code_out   = code_q;
    assign code_valid = cv_q;
    assign tx_serial  = tx_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_hamming_enc_tx.sv
// -----------------------------------------------------------------------------
// tb_hamming_enc_tx
// Bench for hamming_enc_tx with CLKS_PER_BIT = 4. The reference model builds
// the codeword from the general Hamming rule (data fills the non-power-of-two
// positions, parity p covers every position whose index has bit p set) and
// predicts the serial stream per cycle.
// -----------------------------------------------------------------------------
module tb_hamming_enc_tx;

    localparam int C = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] in_data;
    logic [2:0] in_err_pos;
    logic       in_valid;
    logic       in_ready;
    logic [7:1] code_out;
    logic       code_valid;
    logic       tx_serial;
    logic       busy;

    int tests_run    = 0;
    int tests_failed = 0;

    hamming_enc_tx #(.CLKS_PER_BIT(C)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_data    (in_data),
        .in_err_pos (in_err_pos),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .code_out   (code_out),
        .code_valid (code_valid),
        .tx_serial  (tx_serial),
        .busy       (busy)
    );

    // clock
    always #5 clock = ~clock;

    // watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference codeword: data bits fill positions that are not powers of two
    // in ascending order; each parity position p is the XOR of every other
    // position whose index has bit p set. Then optional single-bit inversion.
    function automatic logic [7:1] model_code(input logic [3:0] d, input logic [2:0] e);
        logic [7:0] c;
        int k;
        c = '0;
        k = 0;
        for (int i = 1; i < 8; i++) begin
            if ((i & (i - 1)) != 0) begin
                c[i] = d[k];
                k++;
            end
        end
        for (int p = 1; p < 8; p = p * 2) begin
            logic x;
            x = 1'b0;
            for (int i = 1; i < 8; i++)
                if (((i & p) != 0) && (i != p)) x = x ^ c[i];
            c[p] = x;
        end
        if (e != 3'd0) c[e] = ~c[e];
        return c[7:1];
    endfunction

    // Receiver-side syndrome: XOR of indices of all set bits.
    function automatic logic [2:0] syndrome(input logic [7:1] c);
        logic [2:0] s;
        s = '0;
        for (int i = 1; i < 8; i++)
            if (c[i]) s = s ^ 3'(i);
        return s;
    endfunction

    // Send one nibble and check the whole frame cycle by cycle.
    // pulse_mid drives a stray in_valid during the DATA phase.
    task automatic run_frame(input logic [3:0] d, input logic [2:0] e, input bit pulse_mid);
        logic [7:1] exp;
        logic [8:0] bits;
        int waited;
        exp     = model_code(d, e);
        bits[0] = 1'b0;
        for (int i = 1; i < 8; i++) bits[i] = exp[i];
        bits[8] = 1'b1;

        @(negedge clock);
        waited = 0;
        while (in_ready !== 1'b1 && waited < 200) begin
            @(negedge clock);
            waited++;
        end
        chk("ready_before_accept", in_ready, 1);
        in_data    = d;
        in_err_pos = e;
        in_valid   = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        chk("code_out", code_out, exp);
        chk("syndrome_eq_err", syndrome(code_out), e);
        chk("code_valid_pulse", code_valid, 1);
        for (int k = 0; k < 9 * C; k++) begin
            chk("tx_bit", tx_serial, bits[k / C]);
            chk("busy_in_frame", busy, 1);
            chk("ready_low_in_frame", in_ready, 0);
            if (k > 0) chk("code_valid_single", code_valid, 0);
            if (pulse_mid && k == 3 * C + 1) begin
                in_valid   = 1'b1;
                in_data    = ~d;
                in_err_pos = 3'd2;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clock);
        end
        in_valid = 1'b0;
        chk("ready_after_frame", in_ready, 1);
        chk("busy_after_frame", busy, 0);
        chk("tx_idle_after_frame", tx_serial, 1);
        chk("code_valid_after_frame", code_valid, 0);
        chk("code_out_held", code_out, exp);
    endtask

    initial begin : main
        logic [3:0] rd;
        logic [2:0] re;
        int cyc;
        bit got;

        // reset
        reset      = 1'b1;
        in_data    = '0;
        in_err_pos = '0;
        in_valid   = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_tx", tx_serial, 1);
        chk("rst_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_code_valid", code_valid, 0);
        chk("rst_code_out", code_out, 0);
        reset = 1'b0;

        // directed frames
        run_frame(4'b1011, 3'd0, 1'b0);
        chk("code_1011", code_out, 7'b1010101);
        run_frame(4'b0001, 3'd0, 1'b0);
        chk("code_0001", code_out, 7'b0000111);
        run_frame(4'b0001, 3'd5, 1'b0);
        chk("code_0001_err5", code_out, 7'b0010111);

        // stray in_valid during DATA is ignored
        run_frame(4'b0110, 3'd0, 1'b1);

        // back-to-back with in_valid held high
        @(negedge clock);
        in_data    = 4'h0;
        in_err_pos = 3'd0;
        in_valid   = 1'b1;
        @(negedge clock);
        chk("b2b_first_valid", code_valid, 1);
        chk("b2b_first_code", code_out, 7'b0000000);
        in_data = 4'hF;
        cyc = 0;
        got = 1'b0;
        while (cyc < 100) begin
            @(negedge clock);
            cyc++;
            if (code_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            chk("b2b_ready", in_ready, (cyc == 36));
        end
        in_valid = 1'b0;
        chk("b2b_second_seen", got, 1);
        chk("b2b_period", cyc, 37);
        chk("b2b_second_code", code_out, 7'b1111111);
        cyc = 0;
        while (in_ready !== 1'b1 && cyc < 100) begin
            @(negedge clock);
            cyc++;
        end
        chk("b2b_drain", in_ready, 1);

        // reset during DATA bit 3
        @(negedge clock);
        in_data    = 4'b1001;
        in_err_pos = 3'd0;
        in_valid   = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (3 * C + 1) @(negedge clock);
        chk("mid_tx_bit3", tx_serial, model_code(4'b1001, 3'd0) >> 2 & 7'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_tx", tx_serial, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_code_out", code_out, 0);
        @(negedge clock);
        reset = 1'b0;
        run_frame(4'b1100, 3'd0, 1'b0);

        // error position sweep with random data
        for (int e = 0; e < 8; e++) begin
            rd = 4'($urandom_range(0, 15));
            run_frame(rd, 3'(e), 1'b0);
        end

        // randomized frames
        for (int n = 0; n < 20; n++) begin
            rd = 4'($urandom_range(0, 15));
            re = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            run_frame(rd, re, ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/hamming_enc_tx.md
# hamming_enc_tx

Serial Hamming(7,4) transmitter: accepts a 4-bit data nibble over a valid/ready handshake and encodes it into a 7-bit single-error-correcting codeword. It then shifts the codeword out on a framed serial line with start and stop bits. This is the transmit end of the Hamming(7,4) link whose receive side applies the matching syndrome check (parity p1/p2/p4 at codeword positions 1/2/4). An optional single-bit error-injection input lets benches exercise the decoder's correction path.

## Interface
- CLKS_PER_BIT, default 4: clock cycles per serial bit; legal range ≥1.
- clock  input  1  rising-edge clock; the block's only clock.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  4  data nibble d[3:0].
- in_err_pos  input  3  codeword position 1..7 to invert; 0 means no injection. Sampled together with in_data.
- in_valid  input  1  in_data/in_err_pos are valid.
- in_ready  output  1  the block can accept a nibble. High exactly when the FSM is in IDLE.
- code_out  output  7  registered codeword, indexed [7:1] by Hamming position, after any injection.
- code_valid  output  1  one-cycle pulse when code_out updates.
- tx_serial  output  1  serial line; idles high.
- busy  output  1  a frame is in progress (FSM not in IDLE).

## Operation
- Encoding maps data bits to codeword positions:
  - c[3]=d[0], c[5]=d[1], c[6]=d[2], c[7]=d[3].
  - c[1]=d0^d1^d3, c[2]=d0^d2^d3, c[4]=d1^d2^d3.
- Injection: if in_err_pos≠0, bit c[in_err_pos] is inverted before registering. The injected codeword is used for both code_out and the serial stream.
- Acceptance happens on a rising edge with in_valid & in_ready. On that edge the block registers the codeword, asserts code_valid for one cycle, and enters START.
- FSM states: IDLE → START → DATA → STOP → IDLE. Each bit is held for CLKS_PER_BIT cycles.
  - IDLE: tx_serial=1.
  - START: tx_serial=0.
  - DATA: 7 bits in position order, c[1] first and c[7] last. A 3-bit index counts 1..7.
  - STOP: tx_serial=1; on completion the FSM returns to IDLE.
- Counters:
  - The bit-timer is $clog2(CLKS_PER_BIT) bits wide, minimum 1. It counts 0..CLKS_PER_BIT-1 and wraps.
  - When CLKS_PER_BIT=1, every state lasts one cycle.
- in_valid while busy is ignored. No buffering; the upstream holds its data until in_ready.
- The block accepts no input in STOP. The next frame can start only from IDLE.
- Reset values: state IDLE, tx_serial=1, in_ready=1, busy=0, code_valid=0, code_out=0, counters 0.
- Reset mid-frame aborts immediately (asynchronously): tx_serial goes to 1, and there is no partial-frame completion.
- An in_err_pos value outside 1..7 cannot occur (3 bits). The value 0 means clean.

## Timing
- in_ready is combinational from state. tx_serial, code_out, code_valid and busy are registered.
- Accept at edge N:
  - START bit is driven for cycles N+1..N+CLKS_PER_BIT.
  - code_valid is high during cycle N+1.
  - busy rises at N+1.
- Frame length is 9·CLKS_PER_BIT cycles: 1 start, 7 code bits, 1 stop.
- in_ready is high again at cycle N+9·CLKS_PER_BIT+1.
- With in_valid held high, back-to-back frames have a period of 9·CLKS_PER_BIT+1 cycles (one IDLE cycle between frames).

## Structure
- Shared package hamming_pkg holds:
  - position constants (P1=1, P2=2, P4=4, data positions 3/5/6/7);
  - a state enum for IDLE/START/DATA/STOP;
  - an encode function. The decoder side uses the same package for its syndrome constants.
- One sub-module is natural: hamming_enc, a pure combinational 4→7 encoder instantiated inside hamming_enc_tx. It is reusable standalone and can be checked exhaustively against the decoder.

## Test plan
- Reset, then in_data=4'b1011 with err_pos=0 and CLKS_PER_BIT=4:
  - code_out=7'b1010101 and code_valid pulses once;
  - tx_serial sequence per bit is 0,1,0,1,0,1,0,1,1, each bit lasting 4 cycles, 36 cycles total.
- in_data=4'b0001, err_pos=0 → code_out=7'b0000111. Same data with err_pos=5 → code_out=7'b0010111; serial bit 5 is inverted.
- All 16 nibbles through hamming_enc into the decoder, err_pos swept 0..7 → decoder output equals the clean codeword. NOERROR is asserted only when err_pos=0.
- in_valid held high with nibbles 4'h0 then 4'hF → codewords 7'b0000000 then 7'b1111111. The second frame is accepted exactly 37 cycles after the first; in_ready is low throughout each frame.
- in_valid pulsed during DATA → ignored: no code_valid, and the frame is unchanged.
- Assert reset during DATA bit 3 → tx_serial=1 and busy=0 in the same cycle, in_ready=1. A new nibble after release produces a complete, correct frame.
